// File: rtl/regfile_copy_ctrl.sv
// rtl/regfile_copy_ctrl.sv - register-file block copy sequencer with 2-entry write skid buffer
// One command at a time: ascending reads, skid-buffered writes, done/err on finish, overlap reject or abort.
module regfile_copy_ctrl #(
  parameter int ADDR_W = 9,
  parameter int N      = 256,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [N-1:0]      rd_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [N-1:0]      wr_data
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_src, r_dst;
  logic [LEN_W-1:0]  r_len, r_reads, r_writes;
  logic              r_inflight, r_err, r_head;
  logic [1:0]        r_occ;
  logic [N-1:0]      r_buf [2];

  logic              w_accept, w_overlap, w_wr_fire, w_last_wr, w_abort;
  logic              w_push, w_pop, w_room, w_rd_en, w_wr_valid;
  logic [ADDR_W:0]   w_src_x, w_dst_x, w_src_end;
  logic [2:0]        w_pend;

  assign w_accept  = (r_state == S_IDLE) && cmd_valid;
  // Unwrapped compare: only a destination strictly inside the source window is unsafe for ascending copy.
  assign w_src_x   = {1'b0, cmd_src};
  assign w_dst_x   = {1'b0, cmd_dst};
  assign w_src_end = w_src_x + cmd_len;
  assign w_overlap = (w_dst_x > w_src_x) && (w_dst_x < w_src_end);

  assign w_wr_valid = (r_state == S_RUN) && (r_occ != 2'd0);
  assign w_wr_fire  = w_wr_valid && wr_ready;
  assign w_last_wr  = w_wr_fire && ((r_writes + LEN_ONE) == r_len);
  assign w_abort    = (r_state == S_RUN) && abort && !w_last_wr;

  // A read may issue only if its data will find a free slot when it lands next cycle.
  assign w_pend  = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_room  = w_pend < (3'd2 + {2'b00, w_wr_fire});
  assign w_rd_en = (r_state == S_RUN) && !abort && (r_reads < r_len) && w_room;
  assign w_push  = (r_state == S_RUN) && r_inflight;
  assign w_pop   = w_wr_fire;

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
  assign err       = r_err;
  assign rd_en     = w_rd_en;
  assign rd_addr   = r_src + r_reads[ADDR_W-1:0];
  assign wr_valid  = w_wr_valid;
  assign wr_addr   = r_dst + r_writes[ADDR_W-1:0];
  assign wr_data   = r_buf[r_head];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = ((cmd_len == '0) || w_overlap) ? S_FIN : S_RUN;
      S_RUN:  if (w_last_wr || abort) w_next = S_FIN;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src      <= '0;
      r_dst      <= '0;
      r_len      <= '0;
      r_reads    <= '0;
      r_writes   <= '0;
      r_inflight <= 1'b0;
      r_err      <= 1'b0;
      r_head     <= 1'b0;
      r_occ      <= 2'd0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
    end else if (w_accept) begin
      r_src      <= cmd_src;
      r_dst      <= cmd_dst;
      r_len      <= cmd_len;
      r_reads    <= '0;
      r_writes   <= '0;
      r_inflight <= 1'b0;
      r_err      <= w_overlap;
      r_head     <= 1'b0;
      r_occ      <= 2'd0;
    end else if (r_state == S_RUN) begin
      if (w_abort) begin
        r_err      <= 1'b1;
        r_inflight <= 1'b0;
        r_occ      <= 2'd0;
      end else begin
        r_inflight <= w_rd_en;
        if (w_rd_en) r_reads <= r_reads + LEN_ONE;
        if (w_pop) begin
          r_writes <= r_writes + LEN_ONE;
          r_head   <= ~r_head;
        end
        if (w_push) r_buf[r_head ^ r_occ[0]] <= rd_data;
        r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

endmodule

// File: tb/tb_regfile_copy_ctrl.sv
// tb/tb_regfile_copy_ctrl.sv - scoreboard bench for regfile_copy_ctrl
// Expected writes/done come from a per-command reference model; a monitor pops and compares.
module tb_regfile_copy_ctrl;
  localparam int AW = 9;
  localparam int N  = 256;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_src = '0;
  logic [AW-1:0] cmd_dst = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          abort = 1'b0;
  logic          busy, done, err, rd_en, wr_valid;
  logic          wr_ready = 1'b1;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [N-1:0]  rd_data = '0;
  logic [N-1:0]  wr_data;

  regfile_copy_ctrl #(.ADDR_W(AW), .N(N), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .abort(abort),
    .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [N-1:0]  mem [512];
  logic [AW-1:0] exp_addr_q [$];
  logic [N-1:0]  exp_data_q [$];
  bit            exp_err_q  [$];
  int            exp_cyc_q  [$];

  int mode = 0, ph = 0, abort_k = 0, abort_cyc = -1;
  int rd_cnt = 0, wr_cnt = 0, wv_cnt = 0, first_rd = -1, first_wv = -1;
  int done_cnt = 0, done_cyc = -1, last_t = 0;
  bit            prev_stall = 0;
  logic [AW-1:0] prev_addr, m_a;
  logic [N-1:0]  prev_data, m_d;
  bit            m_e;
  int            m_c;

  always @(posedge clk) cyc <= cyc + 1;

  // Source memory: data valid one cycle after rd_en, junk otherwise.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : {8{$urandom}};

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write sink and abort driver.
  always @(negedge clk) begin
    ph++;
    case (mode)
      0: wr_ready = 1'b1;
      1: wr_ready = (ph % 3 == 0);
      default: wr_ready = ($urandom_range(0, 3) != 0);
    endcase
    abort = (abort_k > 0) && wr_valid && wr_ready && (wr_cnt == abort_k - 1);
    if (abort) abort_cyc = cyc;
  end

  // Monitor: pops the scoreboard on every write fire and done pulse.
  always @(negedge clk) begin
    #4;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        rd_cnt = 0; wr_cnt = 0; wv_cnt = 0; first_rd = -1; first_wv = -1;
      end
      if (rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (wr_valid) begin
        wv_cnt++;
        if (first_wv < 0) first_wv = cyc;
      end
      if (prev_stall) begin
        chk("stall_valid", wr_valid, 1);
        chk("stall_addr", wr_addr, prev_addr);
        chk("stall_data", wr_data, prev_data);
      end
      if (wr_valid && wr_ready) begin
        if (exp_addr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0h, no write expected", wr_addr);
        end else begin
          m_a = exp_addr_q.pop_front();
          m_d = exp_data_q.pop_front();
          chk("wr_addr", wr_addr, m_a);
          chk("wr_data", wr_data, m_d);
        end
        wr_cnt++;
      end
      if (rd_en) chk("outstanding_le2", (rd_cnt - wr_cnt) <= 2, 1);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 required none");
        end else begin
          m_e = exp_err_q.pop_front();
          m_c = exp_cyc_q.pop_front();
          chk("done_err", err, m_e);
          if (m_c >= 0) chk("done_cycle", done_cyc, m_c);
        end
      end
      prev_stall = wr_valid && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end
  end

  task automatic issue_cmd(input int s, input int d, input int l, input int m, input int k, output int t);
    int n = 0;
    bit ovl;
    int nw;
    while (!cmd_ready && n < 200) begin @(negedge clk); #3; n++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_ready_timeout: got cmd_ready=0 required 1");
    end
    ovl = (d > s) && (d < s + l);
    mode = m;
    abort_k = (ovl || l == 0) ? 0 : k;
    nw = ovl ? 0 : ((abort_k > 0 && abort_k < l) ? abort_k : l);
    for (int i = 0; i < nw; i++) begin
      exp_addr_q.push_back(AW'((d + i) % 512));
      exp_data_q.push_back(mem[(s + i) % 512]);
    end
    exp_err_q.push_back(ovl || (abort_k > 0 && abort_k < l));
    t = cyc;
    exp_cyc_q.push_back((m == 0 && abort_k == 0) ? ((l == 0 || ovl) ? t + 1 : t + l + 3) : -1);
    cmd_src = AW'(s); cmd_dst = AW'(d); cmd_len = LW'(l); cmd_valid = 1'b1;
    @(negedge clk); #3;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int start);
    int n = 0;
    while (done_cnt == start && n < 3000) begin @(negedge clk); #3; n++; end
    if (done_cnt == start) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done within %0d cycles required done", n);
    end
  endtask

  task automatic run(input int s, input int d, input int l, input int m, input int k);
    int st, t;
    st = done_cnt;
    issue_cmd(s, d, l, m, k, t);
    wait_done(st);
    abort_k = 0;
    last_t = t;
    chk("writes_left", exp_addr_q.size(), 0);
    exp_addr_q.delete(); exp_data_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_wr_valid"}, wr_valid, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running required finish");
    $fatal(1);
  end

  initial begin
    int st, t, n, s, d, l, k;
    for (int i = 0; i < 512; i++) mem[i] = {8{$urandom}} ^ {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    repeat (3) @(negedge clk);
    #3;
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk); #3;
    chk("reset_cmd_ready", cmd_ready, 1);

    run(16'h010, 16'h100, 4, 0, 0);
    chk("t1_first_rd", first_rd, last_t + 1);
    chk("t1_first_wv", first_wv, last_t + 3);
    chk("t1_reads", rd_cnt, 4);
    chk("t1_writes", wr_cnt, 4);

    run(16'h010, 16'h100, 4, 1, 0);
    chk("t2_reads", rd_cnt, 4);
    chk("t2_writes", wr_cnt, 4);

    run(16'h1FE, 16'h000, 4, 0, 0);
    chk("t3_writes", wr_cnt, 4);

    run(16'h020, 16'h022, 4, 0, 0);
    chk("t4_ovl_reads", rd_cnt, 0);
    chk("t4_ovl_wvalid", wv_cnt, 0);
    run(16'h020, 16'h022, 0, 0, 0);
    chk("t4_len0_reads", rd_cnt, 0);
    chk("t4_len0_wvalid", wv_cnt, 0);

    run(100, 300, 16, 0, 3);
    chk("t5_writes", wr_cnt, 3);
    chk("t5_done_after_abort", done_cyc, abort_cyc + 1);
    @(negedge clk); #3;
    chk("t5_cmd_ready", cmd_ready, 1);

    run(7, 200, 5, 0, 5);
    chk("abort_last_writes", wr_cnt, 5);

    st = done_cnt;
    issue_cmd(64, 128, 8, 0, 0, t);
    n = 0;
    while (wr_cnt < 3 && n < 100) begin @(negedge clk); #3; n++; end
    chk("t6_progress", wr_cnt >= 3, 1);
    rst = 1'b1;
    @(negedge clk); #3;
    check_outputs_zero("t6");
    exp_addr_q.delete(); exp_data_q.delete(); exp_err_q.delete(); exp_cyc_q.delete();
    rst = 1'b0;
    repeat (3) begin @(negedge clk); #3; end
    chk("t6_no_done", done_cnt, st);
    run(64, 128, 8, 0, 0);
    chk("t6_after_writes", wr_cnt, 8);

    for (int i = 0; i < 25; i++) begin
      s = $urandom_range(0, 511);
      l = $urandom_range(0, 24);
      if ($urandom_range(0, 2) == 0) d = (s + $urandom_range(0, 6)) % 512;
      else d = $urandom_range(0, 511);
      k = ($urandom_range(0, 3) == 0 && l > 0) ? $urandom_range(1, l) : 0;
      run(s, d, l, $urandom_range(0, 2), k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
